// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants and state types for the sram-like to AXI3 bridge.
// IDs, fixed AXI attribute values and the read/write FSM encodings live here.
package sram_axi_bridge_pkg;

  localparam logic [3:0] AXI_ID_INST     = 4'd0;
  localparam logic [3:0] AXI_ID_DATA     = 4'd1;

  localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

  typedef enum logic {
    AR_IDLE,
    AR_SEND
  } ar_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SEND,
    W_RESP
  } w_state_t;

  function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
    return {1'b0, sram_size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// Bundle of the core's inst/data sram-like ports and the AXI3 master port.
// Modport master is the bridge side; modport slave is the core plus interconnect.
interface sram_axi_bridge_if;

  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/sram_axi_bridge_wr_ctrl.sv
// Data-port write path: accepts one write, runs AW and W independently, waits for B.
//  state  | meaning
//  W_IDLE | no write outstanding, may accept a data write
//  W_SEND | AW and/or W still waiting for their handshakes
//  W_RESP | address and data sent, waiting for B
module sram_axi_bridge_wr_ctrl
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic        data_rd_pend,
  input  logic        data_rd_acc,
  output logic        wr_acc,
  output logic        wr_pend,
  output logic        b_ok,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  w_state_t w_state;
  logic     aw_done;
  logic     w_done;
  logic     aw_now;
  logic     w_now;

  assign wr_acc  = (w_state == W_IDLE) && data_req && data_wr && !data_rd_pend && !data_rd_acc;
  assign wr_pend = (w_state != W_IDLE);
  assign b_ok    = (w_state == W_RESP) && bvalid && bready;

  // A channel counts as done either from an earlier cycle or from this cycle's handshake.
  assign aw_now  = aw_done || (awvalid && awready);
  assign w_now   = w_done || (wvalid && wready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      awaddr  <= '0;
      awsize  <= '0;
      awvalid <= 1'b0;
      wdata   <= '0;
      wstrb   <= '0;
      wvalid  <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      bready <= 1'b1;
      case (w_state)
        W_IDLE: begin
          if (wr_acc) begin
            awaddr  <= data_addr;
            awsize  <= axi_size(data_size);
            wdata   <= data_wdata;
            wstrb   <= data_wstrb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_SEND;
          end
        end
        W_SEND: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          aw_done <= aw_now;
          w_done  <= w_now;
          if (aw_now && w_now) w_state <= W_RESP;
        end
        W_RESP: begin
          if (bvalid && bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridge from the core's sram-like inst/data ports to one AXI3 master, single beats only.
//  state   | meaning
//  AR_IDLE | free to accept one read (data port has priority)
//  AR_SEND | arvalid held with the latched request until arready
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ID_INST = AXI_ID_INST,
  parameter logic [3:0] ID_DATA = AXI_ID_DATA
) (
  input  logic              clk,
  input  logic              reset,
  sram_axi_bridge_if.master bus,
  output logic [3:0]        axi_arid
);

  ar_state_t ar_state;
  logic      inst_rd_pend;
  logic      data_rd_pend;
  logic      wr_pend;
  logic      data_rd_acc;
  logic      inst_rd_acc;
  logic      wr_acc;
  logic      b_ok;
  logic      r_fire;

  // A data read waits for any write in flight so data responses stay in request order.
  assign data_rd_acc = (ar_state == AR_IDLE) && bus.data_req && !bus.data_wr
                       && !data_rd_pend && !wr_pend;
  assign inst_rd_acc = (ar_state == AR_IDLE) && bus.inst_req && !bus.inst_wr
                       && !inst_rd_pend && !data_rd_acc;
  assign r_fire      = bus.rvalid && bus.rready;

  assign bus.inst_addr_ok = inst_rd_acc;
  assign bus.data_addr_ok = data_rd_acc || wr_acc;
  assign bus.inst_data_ok = r_fire && (bus.rid == ID_INST);
  assign bus.data_data_ok = (r_fire && (bus.rid == ID_DATA)) || b_ok;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;
  assign axi_arid         = bus.rid;

  assign bus.arlen   = AXI_LEN_SINGLE;
  assign bus.arburst = AXI_BURST_INCR;
  assign bus.arlock  = AXI_LOCK_NORMAL;
  assign bus.arcache = AXI_CACHE_NONE;
  assign bus.arprot  = AXI_PROT_NONE;
  assign bus.awid    = ID_DATA;
  assign bus.awlen   = AXI_LEN_SINGLE;
  assign bus.awburst = AXI_BURST_INCR;
  assign bus.awlock  = AXI_LOCK_NORMAL;
  assign bus.awcache = AXI_CACHE_NONE;
  assign bus.awprot  = AXI_PROT_NONE;
  assign bus.wid     = ID_DATA;
  assign bus.wlast   = 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ar_state     <= AR_IDLE;
      bus.arvalid  <= 1'b0;
      bus.araddr   <= '0;
      bus.arsize   <= '0;
      bus.arid     <= '0;
      bus.rready   <= 1'b0;
      inst_rd_pend <= 1'b0;
      data_rd_pend <= 1'b0;
    end else begin
      bus.rready <= 1'b1;
      if (r_fire && (bus.rid == ID_INST)) inst_rd_pend <= 1'b0;
      if (r_fire && (bus.rid == ID_DATA)) data_rd_pend <= 1'b0;
      case (ar_state)
        AR_IDLE: begin
          if (data_rd_acc) begin
            bus.araddr   <= bus.data_addr;
            bus.arsize   <= axi_size(bus.data_size);
            bus.arid     <= ID_DATA;
            bus.arvalid  <= 1'b1;
            data_rd_pend <= 1'b1;
            ar_state     <= AR_SEND;
          end else if (inst_rd_acc) begin
            bus.araddr   <= bus.inst_addr;
            bus.arsize   <= axi_size(bus.inst_size);
            bus.arid     <= ID_INST;
            bus.arvalid  <= 1'b1;
            inst_rd_pend <= 1'b1;
            ar_state     <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            ar_state    <= AR_IDLE;
          end
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  sram_axi_bridge_wr_ctrl u_wr_ctrl (
    .clk          (clk),
    .reset        (reset),
    .data_req     (bus.data_req),
    .data_wr      (bus.data_wr),
    .data_size    (bus.data_size),
    .data_wstrb   (bus.data_wstrb),
    .data_addr    (bus.data_addr),
    .data_wdata   (bus.data_wdata),
    .data_rd_pend (data_rd_pend),
    .data_rd_acc  (data_rd_acc),
    .wr_acc       (wr_acc),
    .wr_pend      (wr_pend),
    .b_ok         (b_ok),
    .awaddr       (bus.awaddr),
    .awsize       (bus.awsize),
    .awvalid      (bus.awvalid),
    .awready      (bus.awready),
    .wdata        (bus.wdata),
    .wstrb        (bus.wstrb),
    .wvalid       (bus.wvalid),
    .wready       (bus.wready),
    .bvalid       (bus.bvalid),
    .bready       (bus.bready)
  );

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: stimulus pushes expected AXI beats and sram
// responses into queues; a negedge monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_sram_axi_bridge;
  import sram_axi_bridge_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] axi_arid;

  sram_axi_bridge_if bus ();

  sram_axi_bridge dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.master),
    .axi_arid (axi_arid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [2:0] size; logic [3:0] id; } addr_exp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } w_exp_t;
  typedef struct { logic is_wr; logic [31:0] rdata; } rsp_exp_t;

  addr_exp_t   exp_ar[$];
  addr_exp_t   exp_aw[$];
  w_exp_t      exp_w[$];
  logic [31:0] exp_inst[$];
  rsp_exp_t    exp_data[$];

  int n_vec = 0;
  int n_err = 0;

  addr_exp_t   m_ar, m_aw;
  w_exp_t      m_w;
  logic [31:0] m_inst;
  rsp_exp_t    m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every handshake or data_ok the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.arvalid && bus.arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
        else begin
          m_ar = exp_ar.pop_front();
          chk("ar_addr", bus.araddr, m_ar.addr);
          chk("ar_size", 32'(bus.arsize), 32'(m_ar.size));
          chk("ar_id", 32'(bus.arid), 32'(m_ar.id));
          chk("ar_len_burst", {22'd0, bus.arlen, bus.arburst}, {22'd0, 8'd0, 2'b01});
        end
      end
      if (bus.awvalid && bus.awready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
        else begin
          m_aw = exp_aw.pop_front();
          chk("aw_addr", bus.awaddr, m_aw.addr);
          chk("aw_size", 32'(bus.awsize), 32'(m_aw.size));
          chk("aw_id", 32'(bus.awid), 32'(m_aw.id));
        end
      end
      if (bus.wvalid && bus.wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
        else begin
          m_w = exp_w.pop_front();
          chk("w_data", bus.wdata, m_w.data);
          chk("w_strb_last_id", {26'd0, bus.wstrb, bus.wlast, bus.wid == AXI_ID_DATA},
              {26'd0, m_w.strb, 1'b1, 1'b1});
        end
      end
      if (bus.inst_data_ok) begin
        if (exp_inst.size() == 0) chk("inst_rsp_unexpected", 32'd1, 32'd0);
        else begin
          m_inst = exp_inst.pop_front();
          chk("inst_rdata", bus.inst_rdata, m_inst);
          chk("inst_rsp_id", 32'(axi_arid), 32'(AXI_ID_INST));
        end
      end
      if (bus.data_data_ok) begin
        if (exp_data.size() == 0) chk("data_rsp_unexpected", 32'd1, 32'd0);
        else begin
          m_data = exp_data.pop_front();
          chk("data_rsp_kind", 32'(bus.bvalid && bus.bready), 32'(m_data.is_wr));
          if (!m_data.is_wr) chk("data_rdata", bus.data_rdata, m_data.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_hs();
    int i = 0;
    while (!bus.arvalid && i < 20) begin
      tick();
      i++;
    end
    chk("ar_wait_timeout", 32'(bus.arvalid), 32'd1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    bus.rid = id;
    bus.rdata = d;
    bus.rvalid = 1'b1;
    #1;
    chk("r_inst_ok", 32'(bus.inst_data_ok), 32'(id == AXI_ID_INST));
    chk("r_data_ok", 32'(bus.data_data_ok), 32'(id == AXI_ID_DATA));
    tick();
    bus.rvalid = 1'b0;
    #1;
    chk("r_ok_pulse", {30'd0, bus.inst_data_ok, bus.data_data_ok}, 32'd0);
  endtask

  task automatic inst_read(input logic [31:0] a, input logic [31:0] d);
    bus.inst_req = 1'b1;
    bus.inst_wr = 1'b0;
    bus.inst_size = 2'd2;
    bus.inst_addr = a;
    #1;
    chk("inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    exp_ar.push_back('{a, 3'd2, AXI_ID_INST});
    tick();
    bus.inst_req = 1'b0;
    chk("inst_arvalid", 32'(bus.arvalid), 32'd1);
    ar_hs();
    exp_inst.push_back(d);
    r_beat(AXI_ID_INST, d);
  endtask

  task automatic data_read(input logic [31:0] a);
    bus.data_req = 1'b1;
    bus.data_wr = 1'b0;
    bus.data_size = 2'd2;
    bus.data_addr = a;
    #1;
    chk("data_rd_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    exp_ar.push_back('{a, 3'd2, AXI_ID_DATA});
    tick();
    bus.data_req = 1'b0;
    ar_hs();
  endtask

  task automatic data_write_accept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.data_req = 1'b1;
    bus.data_wr = 1'b1;
    bus.data_size = 2'd2;
    bus.data_addr = a;
    bus.data_wdata = d;
    bus.data_wstrb = s;
    #1;
    chk("data_wr_addr_ok", 32'(bus.data_addr_ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw_cnt, w_cnt;
    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_wstrb = 0;
    bus.inst_addr = 0; bus.inst_wdata = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 1; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;

    // reset values
    tick(); tick();
    chk("rst_valids", {29'd0, bus.arvalid, bus.awvalid, bus.wvalid}, 32'd0);
    chk("rst_readies", {30'd0, bus.rready, bus.bready}, 32'd0);
    chk("rst_oks", {28'd0, bus.inst_addr_ok, bus.inst_data_ok, bus.data_addr_ok, bus.data_data_ok}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rready_after_rst", 32'(bus.rready), 32'd1);
    chk("bready_after_rst", 32'(bus.bready), 32'd1);

    // 1: single inst read
    inst_read(32'h1c00_0000, 32'h0280_0c0c);

    // inst writes are never accepted
    bus.inst_req = 1'b1; bus.inst_wr = 1'b1; #1;
    chk("inst_wr_rejected", 32'(bus.inst_addr_ok), 32'd0);
    tick();
    chk("inst_wr_no_ar", 32'(bus.arvalid), 32'd0);
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0;

    // 2: simultaneous inst and data read requests, data wins
    bus.inst_req = 1'b1; bus.inst_size = 2'd2; bus.inst_addr = 32'h1c00_0200;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'd2; bus.data_addr = 32'h1c00_0100;
    #1;
    chk("t2_data_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    chk("t2_inst_held", 32'(bus.inst_addr_ok), 32'd0);
    exp_ar.push_back('{32'h1c00_0100, 3'd2, AXI_ID_DATA});
    tick();
    bus.data_req = 1'b0;
    #1;
    chk("t2_inst_held_send", 32'(bus.inst_addr_ok), 32'd0);
    chk("t2_arid_data", 32'(bus.arid), 32'(AXI_ID_DATA));
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    #1;
    chk("t2_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    exp_ar.push_back('{32'h1c00_0200, 3'd2, AXI_ID_INST});
    tick();
    bus.inst_req = 1'b0;
    ar_hs();
    exp_inst.push_back(32'h1111_0000);
    r_beat(AXI_ID_INST, 32'h1111_0000);
    exp_data.push_back('{1'b0, 32'h2222_0000});
    r_beat(AXI_ID_DATA, 32'h2222_0000);

    // 3: write, wready immediate, awready after 3 cycles
    data_write_accept(32'h800d_0000, 32'h0000_1234, 4'b0011);
    exp_aw.push_back('{32'h800d_0000, 3'd2, AXI_ID_DATA});
    exp_w.push_back('{32'h0000_1234, 4'b0011});
    tick();
    bus.data_req = 1'b0;
    aw_cnt = 0; w_cnt = 0;
    bus.wready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (bus.awvalid) aw_cnt++;
      if (bus.wvalid) w_cnt++;
      bus.awready = (c == 3);
      tick();
    end
    bus.awready = 1'b0; bus.wready = 1'b0;
    chk("t3_awvalid_cycles", 32'(aw_cnt), 32'd4);
    chk("t3_wvalid_cycles", 32'(w_cnt), 32'd1);
    exp_data.push_back('{1'b1, 32'h0});
    bus.bid = AXI_ID_DATA; bus.bvalid = 1'b1;
    #1;
    chk("t3_b_data_ok", 32'(bus.data_data_ok), 32'd1);
    tick();
    bus.bvalid = 1'b0;
    #1;
    chk("t3_b_pulse", 32'(bus.data_data_ok), 32'd0);

    // 4: data read blocked behind a pending write until B
    data_write_accept(32'h800d_0010, 32'hdead_beef, 4'hf);
    exp_aw.push_back('{32'h800d_0010, 3'd2, AXI_ID_DATA});
    exp_w.push_back('{32'hdead_beef, 4'hf});
    tick();
    bus.data_wr = 1'b0; bus.data_addr = 32'h1c00_0300;
    #1;
    chk("t4_blocked_send", 32'(bus.data_addr_ok), 32'd0);
    bus.awready = 1'b1; bus.wready = 1'b1;
    tick();
    bus.awready = 1'b0; bus.wready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("t4_blocked_resp", 32'(bus.data_addr_ok), 32'd0);
      tick();
    end
    exp_data.push_back('{1'b1, 32'h0});
    bus.bvalid = 1'b1;
    #1;
    chk("t4_blocked_b", 32'(bus.data_addr_ok), 32'd0);
    chk("t4_b_data_ok", 32'(bus.data_data_ok), 32'd1);
    tick();
    bus.bvalid = 1'b0;
    #1;
    chk("t4_rd_addr_ok", 32'(bus.data_addr_ok), 32'd1);
    exp_ar.push_back('{32'h1c00_0300, 3'd2, AXI_ID_DATA});
    tick();
    bus.data_req = 1'b0;
    chk("t4_arvalid", 32'(bus.arvalid), 32'd1);
    chk("t4_arid", 32'(bus.arid), 32'(AXI_ID_DATA));
    ar_hs();
    exp_data.push_back('{1'b0, 32'h3333_4444});
    r_beat(AXI_ID_DATA, 32'h3333_4444);

    // 5: both reads outstanding, data R returns first
    bus.inst_req = 1'b1; bus.inst_wr = 1'b0; bus.inst_size = 2'd2; bus.inst_addr = 32'h1c00_0400;
    #1;
    chk("t5_inst_addr_ok", 32'(bus.inst_addr_ok), 32'd1);
    exp_ar.push_back('{32'h1c00_0400, 3'd2, AXI_ID_INST});
    tick();
    bus.inst_req = 1'b0;
    ar_hs();
    data_read(32'h1c00_0500);
    exp_data.push_back('{1'b0, 32'h5555_aaaa});
    r_beat(AXI_ID_DATA, 32'h5555_aaaa);
    exp_inst.push_back(32'h6666_bbbb);
    r_beat(AXI_ID_INST, 32'h6666_bbbb);

    // 6: reset in W_SEND, then a clean inst read
    data_write_accept(32'h800d_0020, 32'h0000_5555, 4'hf);
    tick();
    bus.data_req = 1'b0;
    chk("t6_in_send", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
    reset = 1'b1;
    #1;
    chk("t6_async_clear", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    inst_read(32'h1c00_0000, 32'h0280_0c0c);

    tick(); tick();
    chk("sb_ar_empty", 32'(exp_ar.size()), 32'd0);
    chk("sb_aw_w_empty", 32'(exp_aw.size() + exp_w.size()), 32'd0);
    chk("sb_rsp_empty", 32'(exp_inst.size() + exp_data.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
